// File: rtl/t_ff_counter.sv
// WIDTH-bit register of T flip-flops that runs either as a bank of independent
// toggle cells or as a synchronous modulo-MODULUS up/down counter with load.
module t_ff_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Mode,
  input  logic             En,
  input  logic [WIDTH-1:0] T,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             Tc,
  output logic             Wrap
);

  // Compares run one bit wider so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_BANK,
    OP_COUNT
  } op_e;

  op_e              op;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic             at_top;
  logic             at_zero;
  logic             in_range;
  logic [WIDTH-1:0] next_q;
  logic             next_wrap;
  logic [WIDTH-1:0] toggle;

  assign q_ext    = {1'b0, Q};
  assign d_ext    = {1'b0, D};
  assign at_top   = (q_ext == TOP_EXT);
  assign at_zero  = (Q == '0);
  assign in_range = (q_ext < MOD_EXT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    next_q    = Q;
    next_wrap = 1'b0;

    if (Load)       op = OP_LOAD;
    else if (!En)   op = OP_HOLD;
    else if (!Mode) op = OP_BANK;
    else            op = OP_COUNT;

    unique case (op)
      OP_LOAD: begin
        if (Mode && (d_ext >= MOD_EXT)) next_q = TOP;
        else                            next_q = D;
      end
      OP_BANK: begin
        next_q = Q ^ T;
      end
      OP_COUNT: begin
        // Out-of-range values only arise after leaving bank mode; they resolve
        // as a wrap in the direction of travel.
        if (!in_range) begin
          next_q    = Up ? '0 : TOP;
          next_wrap = 1'b1;
        end else if (Up) begin
          if (at_top) begin
            next_q    = '0;
            next_wrap = 1'b1;
          end else begin
            next_q = WIDTH'(q_ext + 1'b1);
          end
        end else begin
          if (at_zero) begin
            next_q    = TOP;
            next_wrap = 1'b1;
          end else begin
            next_q = WIDTH'(q_ext - 1'b1);
          end
        end
      end
      default: begin
        next_q = Q;
      end
    endcase
  end

  // Each storage bit is a T flip-flop; its toggle input is the bit difference.
  assign toggle = Q ^ next_q;

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (Reset) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else begin
      Q    <= Q ^ toggle;
      Wrap <= next_wrap;
    end
  end

  assign Q_bar = ~Q;
  assign Tc    = Mode & En & ~Load & ((Up & at_top) | (~Up & at_zero));

endmodule

// File: doc/t_ff_counter.md
Name: t_ff_counter

Overview:
- Parametrised successor to the single T flip-flop: a WIDTH-bit register built from T flip-flops, with two run modes.
- Bank mode: the bits act as independent toggle flip-flops.
- Count mode: the bits form a synchronous modulo-MODULUS up/down counter with parallel load, terminal-count flag and a wrap pulse.
- Used as the general counter/divider primitive in later lab designs.

Parameters:
- WIDTH, 4, register width in bits; 1..16.
- MODULUS, 10, count-mode modulus; legal range 2..2^WIDTH; counts 0..MODULUS-1.

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- Mode  input  1  0 = toggle bank, 1 = modulo counter.
- En  input  1  advance enable, used in both modes.
- T  input  WIDTH  per-bit toggle vector; bank mode only.
- Up  input  1  count direction: 1 = up, 0 = down; count mode only.
- Load  input  1  synchronous parallel load; both modes.
- D  input  WIDTH  load value.
- Q  output  WIDTH  register state.
- Q_bar  output  WIDTH  bitwise complement of Q at all times.
- Tc  output  1  combinational terminal count.
- Wrap  output  1  registered one-cycle pulse on count-mode wrap.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high, sampled on the rising edge of Clk.
- Storage is WIDTH T flip-flops. The toggle vector is computed as Q XOR next_Q, and each bit toggles when its toggle bit is 1.
- Per-edge priority: Reset > Load > En > hold.
- Reset: Q=0, Q_bar=all ones, Wrap=0, effective at the edge. A Reset that arrives mid-count abandons the count with no Wrap pulse.
- Load (Reset=0, Load=1): Q<=D in bank mode, ignoring En and T.
  - Count mode: Q<=D if D<MODULUS, otherwise Q<=MODULUS-1 (clamped).
  - Load never asserts Wrap.
- Bank mode (Mode=0, En=1, Load=0): Q<=Q^T. T=0 holds. Wrap stays 0. Tc=0.
- Count mode (Mode=1, En=1, Load=0), next state by direction and current Q:
  - Up, Q<MODULUS-1: Q<=Q+1.
  - Up, Q==MODULUS-1: Q<=0, Wrap=1 next cycle.
  - Down, Q>0 and Q<MODULUS: Q<=Q-1.
  - Down, Q==0: Q<=MODULUS-1, Wrap=1 next cycle.
  - Out-of-range Q (>=MODULUS, reachable only via bank mode then a switch to count mode): up goes to 0, down goes to MODULUS-1; Wrap=1 in both cases.
- En=0 (Load=0): Q holds in both modes; Wrap=0 next cycle.
- Tc = Mode & En & ~Load & ((Up & Q==MODULUS-1) | (~Up & Q==0)). Tc is purely combinational, so Tc high at an edge predicts Wrap high in the following cycle.
- Wrap is high for exactly one cycle per wrap event. Back-to-back wraps (MODULUS=2 counting continuously) give Wrap high on consecutive cycles.
- Up, Mode or T changing between edges takes effect at the next edge. Changing Mode does not alter Q.
- Latency: every operation is visible on Q one edge after it is sampled. There are no multi-cycle paths.
- Arithmetic is done WIDTH+1 bits wide so that MODULUS=2^WIDTH compares correctly. In that case out-of-range Q cannot occur.
- No latches. Q_bar is derived from Q, not separately registered.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
1. Reset, then Mode=1, Up=1, En=1 for 12 edges -> Q = 1..9, 0, 1, 2; Tc=1 only while Q=9; Wrap=1 only in the cycle Q first reads 0; Q_bar=~Q throughout.
2. Mode=1, Up=0, En=1 starting from Q=0 -> Q=9, 8, 7; Tc=1 at Q=0; Wrap pulses once with Q=9. Toggle En=0 for 3 edges -> Q holds at 7, Wrap=0.
3. Load priority, Mode=1: Load=1, En=1, D=4 -> Q=4. D=13 -> Q=9 (clamp). Load and Reset asserted together -> Q=0, Wrap=0.
4. Bank mode from Q=0: T=0101 -> Q=0101; T=1111 -> Q=1010; T=0 -> hold; Tc=0 and Wrap=0 throughout.
5. Out-of-range: in bank mode load D=1100, then Mode=1, Up=1 -> Q=0, Wrap=1. Repeat with Up=0 -> Q=9, Wrap=1.
6. MODULUS=2, WIDTH=1, count up continuously -> Q alternates 1, 0, 1, 0 and Wrap is high on every cycle Q=0. Reset asserted mid-sequence -> Q=0 at that edge, Wrap=0 the next cycle.
